fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter DEPTH, default 4, prefetch buffer entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_redirect  input  1  branch/jump taken; flush and restart fetch.
REQ-007 i_redirect_pc  input  XLEN  new fetch target.
REQ-008 o_imem_req  output  1  instruction memory request valid.
REQ-009 o_imem_addr  output  XLEN  request word address.
REQ-010 i_imem_gnt  input  1  request accepted this cycle.
REQ-011 i_imem_rvalid  input  1  response data valid; responses in request order, latency >= 1.
REQ-012 i_imem_rdata  input  32  response instruction word.
REQ-013 o_inst_valid  output  1  buffered instruction available.
REQ-014 o_inst  output  32  head instruction.
REQ-015 o_inst_pc  output  XLEN  PC of head instruction.
REQ-016 i_inst_ready  input  1  consumer accepts head.
REQ-017 o_count  output  $clog2(DEPTH+1)  entries currently buffered.

Function
REQ-018 Request issued when o_imem_req & i_imem_gnt; fetch PC then advances by 4, modulo 2^XLEN.
REQ-019 o_imem_req = (count + outstanding) < DEPTH and not i_redirect and not reset; buffer can never overflow.
REQ-020 o_imem_addr = fetch PC, held stable while o_imem_req is high without i_imem_gnt.
REQ-021 Outstanding counter: +1 on grant, -1 on accepted response, both same cycle = unchanged.
REQ-022 Accepted response (i_imem_rvalid, discard = 0) pushes {resp PC, i_imem_rdata}; resp PC then advances by 4.
REQ-023 Pop on o_inst_valid & i_inst_ready; push and pop in same cycle both occur, count unchanged.
REQ-024 Buffer is registered: response at cycle N visible on o_inst_valid at N+1 earliest; o_inst/o_inst_pc stable while valid & !ready.
REQ-025 On i_redirect: buffer flushed, fetch PC and resp PC <= {i_redirect_pc[XLEN-1:2], 2'b00}, discard <= outstanding minus any response arriving that cycle, outstanding likewise.
REQ-026 While discard > 0, each i_imem_rvalid is dropped, decrements discard and outstanding, and is never pushed.
REQ-027 Redirect overrides same-cycle push and pop; a pop with ready during redirect is not counted as consumed.
REQ-028 Redirect while discard > 0 accumulates: discard = total in-flight requests.
REQ-029 First request after redirect issued the cycle after redirect.
REQ-030 FIFO pointers wrap modulo DEPTH; PC wraps 0xFFFFFFFC -> 0x00000000 with no error.

Reset
REQ-031 On reset: fetch PC and resp PC = RESET_PC, count/outstanding/discard = 0, pointers = 0.
REQ-032 Outputs during/after reset: o_imem_req=0 while reset high, o_inst_valid=0, o_inst=0, o_inst_pc=0, o_count=0.
REQ-033 Reset mid-transaction drops all in-flight responses; memory is required to be reset alongside.

Structure
REQ-034 Shared package klp32_pkg holds XLEN default, INST_W=32, INST_BYTES=4, RESET_PC default.
REQ-035 One sub-module fetch_fifo: synchronous DEPTH-entry FIFO of {XLEN pc, 32 inst} with flush, count output.

Verification
REQ-036 Reset, gnt=1, 1-cycle rvalid, ready=1 -> addresses 0x0,0x4,0x8 in order; o_inst_pc matches; one instruction per cycle sustained.
REQ-037 ready=0 held, DEPTH=4 -> o_count reaches 4, o_imem_req drops, no fifth grant; ready=1 resumes requests.
REQ-038 Two requests outstanding, redirect to 0x103 -> both responses dropped, next addr 0x100, first o_inst_pc=0x100.
REQ-039 Redirect same cycle as rvalid and pop -> response discarded, buffer empty next cycle, count=0.
REQ-040 Redirect to 0xFFFFFFF8 -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-041 Random gnt/rvalid latency 1-5 with random redirects -> in-order PCs, no lost or duplicate instructions versus scoreboard.

Source files
------------

// File: rtl/klp32_pkg.sv
// Shared constants for the KLP32 front end: datapath width, instruction
// size and the default boot address.
package klp32_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INST_W       = 32;
  localparam int INST_BYTES   = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {pc, instruction} pairs with a
// single-cycle flush and an occupancy count.
module fetch_fifo
  import klp32_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [XLEN-1:0]            push_pc,
  input  logic [INST_W-1:0]          push_inst,
  input  logic                       pop,
  output logic                       valid,
  output logic [XLEN-1:0]            head_pc,
  output logic [INST_W-1:0]          head_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     used;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (used != '0);
  assign do_push = push && ((used != FULL) || do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= used - CW'(1);
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]   <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign valid     = (used != '0);
  assign head_pc   = valid ? pc_mem[rd_ptr]   : '0;
  assign head_inst = valid ? inst_mem[rd_ptr] : '0;
  assign count     = used;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word requests to instruction memory,
// buffers in-order responses and discards responses made stale by redirects.
module fetch_unit
  import klp32_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_redirect,
  input  logic [XLEN-1:0]            i_redirect_pc,
  output logic                       o_imem_req,
  output logic [XLEN-1:0]            o_imem_addr,
  input  logic                       i_imem_gnt,
  input  logic                       i_imem_rvalid,
  input  logic [INST_W-1:0]          i_imem_rdata,
  output logic                       o_inst_valid,
  output logic [INST_W-1:0]          o_inst,
  output logic [XLEN-1:0]            o_inst_pc,
  input  logic                       i_inst_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN   = ~XLEN'(INST_BYTES - 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW:0]     in_flight;
  logic            req_fire;
  logic            rsp_fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic            inst_valid;

  // Buffered plus in-flight words never exceed DEPTH, so a push always fits.
  assign in_flight   = {1'b0, count} + {1'b0, outstanding};
  assign o_imem_req  = (in_flight < DEPTH_W) && !i_redirect && !reset;
  assign o_imem_addr = fetch_pc;

  assign req_fire        = o_imem_req && i_imem_gnt;
  assign rsp_fire        = i_imem_rvalid && (outstanding != '0);
  assign rsp_drop        = rsp_fire && (discard != '0);
  assign push            = rsp_fire && !rsp_drop && !i_redirect;
  assign pop             = inst_valid && i_inst_ready && !i_redirect;
  assign redirect_target = i_redirect_pc & ALIGN;

  // A redirect marks every request still in flight as stale; the counter
  // adds to any discards already pending because it starts from outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (i_redirect) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        discard  <= outstanding - CW'(rsp_fire);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (push)     resp_pc  <= resp_pc + STEP;
        if (rsp_drop) discard  <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (i_redirect),
    .push      (push),
    .push_pc   (resp_pc),
    .push_inst (i_imem_rdata),
    .pop       (pop),
    .valid     (inst_valid),
    .head_pc   (o_inst_pc),
    .head_inst (o_inst),
    .count     (count)
  );

  assign o_inst_valid = inst_valid;
  assign o_count      = count;

endmodule
